// File: rtl/evo_truth_table_tester.sv
// Stimulus/capture stage for one evolved 5-in/1-out circuit: sweeps all
// input vectors, samples the synchronized output, scores vs expected table.
// Ports: clk, rst_n, start, expected -> dut_in, busy, done, pass,
//        observed, mismatch_count, unstable; dut_out is the async CUT output.
module evo_truth_table_tester #(
  parameter int NUM_INPUTS    = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2**NUM_INPUTS-1:0]   expected,
  output logic [NUM_INPUTS-1:0]      dut_in,
  input  logic                       dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [2**NUM_INPUTS-1:0]   observed,
  output logic [NUM_INPUTS:0]        mismatch_count,
  output logic                       unstable
);

  localparam int NV   = 2**NUM_INPUTS;
  localparam int CMAX = (SETTLE_CYCLES > NUM_SAMPLES) ?
                        SETTLE_CYCLES : NUM_SAMPLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SET_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SMP_END = CW'(NUM_SAMPLES - 1);
  localparam logic [NUM_INPUTS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [NUM_INPUTS-1:0]   r_idx;
  logic [NV-1:0]           r_exp;
  logic                    r_first;
  logic                    r_sync1;
  logic                    r_sync2;

  logic                    w_first;
  logic                    w_miss;
  logic                    w_flip;
  logic [NUM_INPUTS:0]     w_mm_next;
  logic                    w_unst_next;

  // Two-flop synchronizer; r_sync2 is the sampled signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= dut_out;
      r_sync2 <= r_sync1;
    end
  end

  // Score updates for the current cycle, shared by the FSM
  // and the registered pass computation on entry to DONE.
  always_comb begin
    w_first     = (r_state == SAMPLE) && (r_cnt == '0);
    w_miss      = w_first && (r_sync2 != r_exp[r_idx]);
    w_flip      = (r_state == SAMPLE) && (r_cnt != '0) &&
                  (r_sync2 != r_first);
    w_mm_next   = mismatch_count +
                  {{NUM_INPUTS{1'b0}}, w_miss};
    w_unst_next = unstable | w_flip;
  end

  assign dut_in = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_exp          <= '0;
      r_first        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      observed       <= '0;
      mismatch_count <= '0;
      unstable       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state        <= SETTLE;
            r_exp          <= expected;
            r_cnt          <= '0;
            r_idx          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            observed       <= '0;
            mismatch_count <= '0;
            unstable       <= 1'b0;
          end
        end
        SETTLE: begin
          if (r_cnt == SET_END) begin
            r_state <= SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          // First sample defines the observed bit;
          // later ones only detect disagreement.
          if (w_first) begin
            observed[r_idx] <= r_sync2;
            r_first         <= r_sync2;
          end
          mismatch_count <= w_mm_next;
          unstable       <= w_unst_next;
          if (r_cnt == SMP_END) begin
            r_cnt <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= DONE;
              r_idx   <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_mm_next == '0) && !w_unst_next;
            end else begin
              r_state <= SETTLE;
              r_idx   <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
